ysyx_24090003_lsu_wb: RTL and testbench
=======================================

YSYX_24090003_LSU_WB -- requirements
Module: ysyx_24090003_lsu_wb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have ports: cpu_clk in 1 clock; cpu_rs in 1 reset (synchronous, active-high).
REQ-003 SHALL have execute-side ports: ex_valid in 1 op offered; ex_ready out 1 op accepted when both high; is_load in 1; is_store in 1; funct3 in 3 RV32I width code; addr in 32 effective address; store_data in 32 rs2 value; alu_result in 32 non-memory result; rd_in in 5 destination register.
REQ-004 SHALL have memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_wen out 1 (1 = store); mem_addr out 32; mem_wdata out 32; mem_wmask out 4; mem_resp_valid in 1; mem_rdata in 32.
REQ-005 SHALL have register-file write ports: rf_wen out 1; rf_rd out 5; rf_wdata out 32; plus lsu_done out 1 (retire pulse) and lsu_misalign out 1.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT, WB; ex_ready = 1 only in IDLE.
REQ-007 SHALL, on handshake in IDLE, register funct3, addr, store_data, alu_result and rd_in; a load/store goes to REQ, any other op goes to WB.
REQ-008 SHALL, in REQ, hold mem_req_valid = 1 with stable mem_req_wen/mem_addr/mem_wdata/mem_wmask until mem_req_ready, then go to WAIT.
REQ-009 SHALL drive mem_addr = {addr[31:2],2'b00}, so addresses are always word-aligned.
REQ-010 SHALL generate stores as follows: sb mask 4'b0001<<addr[1:0] with the byte replicated 4x; sh mask 4'b0011<<{addr[1],1'b0} with the half replicated 2x; sw mask 4'b1111; other funct3 codes are treated as sw.
REQ-011 SHALL sample mem_resp_valid only in WAIT; a response in WAIT captures mem_rdata and moves to WB. Responses in any other state are ignored.
REQ-012 SHALL extract loads from the captured word as follows: lb/lbu use the byte at addr[1:0], with sign or zero extension; lh/lhu use the half at addr[1], with sign or zero extension; lw uses the full word; other codes are treated as lw.
REQ-013 SHALL, in WB, assert lsu_done for exactly one cycle and then return to IDLE.
REQ-014 SHALL, in WB, assert rf_wen when the op is non-memory or a load, and rd != 0. Stores never assert rf_wen.
REQ-015 SHALL suppress rf_wen for rd = 0, because the register file does not hardwire x0.
REQ-016 SHALL set rf_wdata to alu_result for non-memory ops and to the extracted load data for loads.
REQ-017 SHALL complete a non-memory op with lsu_done/rf_wen exactly 1 cycle after handshake. A load or store with zero-wait memory completes in 3 cycles after handshake (REQ, WAIT, WB).
REQ-018 SHALL treat is_load and is_store both high as a load.

Reset
REQ-019 SHALL, while cpu_rs is high at a cpu_clk edge, enter IDLE and hold all outputs at 0 except ex_ready, which is 1.
REQ-020 SHALL, on reset in REQ/WAIT/WB, abandon the op: mem_req_valid drops the next cycle, no rf_wen or lsu_done is produced, and a later stray mem_resp_valid is ignored.

Configuration
REQ-021 SHALL, with YSYX_24090003_MISALIGN_CHK_EN defined, send a misaligned access (lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] != 0) from IDLE directly to WB. That access issues no memory request, asserts no rf_wen, and asserts lsu_misalign together with lsu_done.
REQ-022 SHALL, without YSYX_24090003_MISALIGN_CHK_EN, tie lsu_misalign to 0 and execute misaligned accesses per REQ-010/REQ-012 using only the address bits named there.

Structure
REQ-023 SHALL place in package ysyx_24090003_pkg: the state encoding, the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and XLEN.
REQ-024 SHALL put load extraction and sign extension in combinational sub-module ysyx_24090003_load_align; store mask and data generation stays inline.

Verification
REQ-025 SHALL cover: ALU op with alu_result=0x1234, rd=5 -> next cycle rf_wen=1, rf_rd=5, rf_wdata=0x1234, lsu_done=1.
REQ-026 SHALL cover: lb at addr 0x80000003, mem_rdata=0x80FF_FF7F, resp after 2 wait cycles -> rf_wdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-027 SHALL cover: sh at addr 0x80000002, store_data=0xABCD_1234 -> mem_wmask=4'b1100, mem_wdata=0x12341234, mem_addr=0x80000000, rf_wen=0.
REQ-028 SHALL cover: mem_req_ready low for 3 cycles -> mem_req_valid and payload stable for all 4 cycles, ex_ready=0 throughout.
REQ-029 SHALL cover: lw to rd=0 -> lsu_done=1, rf_wen=0; reset asserted in WAIT, then mem_resp_valid pulsed -> no rf_wen, state IDLE.
REQ-030 SHALL cover, with YSYX_24090003_MISALIGN_CHK_EN defined: lw at 0x80000002 -> no mem_req_valid, lsu_misalign=1 and lsu_done=1 one cycle after handshake.

Source files
------------

// File: rtl/ysyx_24090003_pkg.sv
// Shared LSU/writeback types: FSM state encoding, RV32I load/store width codes,
// and the misalignment predicate used when YSYX_24090003_MISALIGN_CHK_EN is defined.
package ysyx_24090003_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Only the named half/word codes are checked; unnamed codes fall back to word ops.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic is_ld,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (is_ld) begin
      mis = (((f3 == LH) || (f3 == LHU)) && off[0]) || ((f3 == LW) && (off != 2'b00));
    end else begin
      mis = ((f3 == SH) && off[0]) || ((f3 == SW) && (off != 2'b00));
    end
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_24090003_load_align.sv
// Combinational load extraction: selects byte/half/word from a memory word
// by address offset and applies sign or zero extension.
module ysyx_24090003_load_align
  import ysyx_24090003_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data = {24'h000000, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LHU:     o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/ysyx_24090003_lsu_wb.sv
// Load/store unit with register-file writeback: IDLE -> REQ -> WAIT -> WB for memory
// ops, IDLE -> WB for everything else. Optional YSYX_24090003_MISALIGN_CHK_EN traps misaligned accesses.
module ysyx_24090003_lsu_wb #(
  parameter int XLEN = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rs,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      rd_in,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            lsu_done,
  output logic            lsu_misalign,
  output logic [1:0]      dbg_state
);

  import ysyx_24090003_pkg::*;

  // Handshake contract: ex_valid/ex_ready transfer an op on a cycle where both are high;
  // mem_req_valid holds with a stable payload until mem_req_ready; mem_resp_valid counts only in WAIT.

  lsu_state_t      r_state;
  logic            r_ex_ready;
  logic            r_mem_req_valid;
  logic            r_mem_wen;
  logic            r_is_load;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_store_data;
  logic [XLEN-1:0] r_alu_result;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rdata;
  logic            r_rf_wen;
  logic            r_lsu_done;
  logic            r_lsu_misalign;

  logic            w_is_mem;
  logic            w_is_store;
  logic            w_misalign;
  logic [3:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  // A load flag wins when both flags are set.
  assign w_is_mem   = is_load | is_store;
  assign w_is_store = is_store & ~is_load;

`ifdef YSYX_24090003_MISALIGN_CHK_EN
  assign w_misalign = w_is_mem && is_misaligned(funct3, is_load, addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = r_store_data;
    case (r_funct3)
      SB: begin
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_store_data[7:0]}};
      end
      SH: begin
        w_wmask = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_store_data[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = r_store_data;
      end
    endcase
  end

  ysyx_24090003_load_align u_load_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_word   (r_rdata),
    .o_data   (w_load_data)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rs) begin
      r_state         <= IDLE;
      r_ex_ready      <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_wen       <= 1'b0;
      r_is_load       <= 1'b0;
      r_funct3        <= 3'b000;
      r_addr          <= '0;
      r_store_data    <= '0;
      r_alu_result    <= '0;
      r_rd            <= 5'd0;
      r_rdata         <= '0;
      r_rf_wen        <= 1'b0;
      r_lsu_done      <= 1'b0;
      r_lsu_misalign  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_valid) begin
            r_funct3     <= funct3;
            r_addr       <= addr;
            r_store_data <= store_data;
            r_alu_result <= alu_result;
            r_rd         <= rd_in;
            r_is_load    <= is_load;
            r_mem_wen    <= w_is_store;
            r_ex_ready   <= 1'b0;
            if (w_misalign) begin
              r_state        <= WB;
              r_lsu_done     <= 1'b1;
              r_lsu_misalign <= 1'b1;
            end else if (w_is_mem) begin
              r_state         <= REQ;
              r_mem_req_valid <= 1'b1;
            end else begin
              r_state    <= WB;
              r_lsu_done <= 1'b1;
              r_rf_wen   <= (rd_in != 5'd0);
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            r_rdata    <= mem_rdata;
            r_state    <= WB;
            r_lsu_done <= 1'b1;
            r_rf_wen   <= r_is_load && (r_rd != 5'd0);
          end
        end
        WB: begin
          r_lsu_done     <= 1'b0;
          r_rf_wen       <= 1'b0;
          r_lsu_misalign <= 1'b0;
          r_ex_ready     <= 1'b1;
          r_state        <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ex_ready      = r_ex_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_wen   = r_mem_wen;
  assign mem_addr      = {r_addr[XLEN-1:2], 2'b00};
  assign mem_wmask     = r_mem_wen ? w_wmask : 4'b0000;
  assign mem_wdata     = r_mem_wen ? w_wdata : '0;
  assign rf_wen        = r_rf_wen;
  assign rf_rd         = r_rd;
  assign rf_wdata      = r_is_load ? w_load_data : r_alu_result;
  assign lsu_done      = r_lsu_done;
  assign lsu_misalign  = r_lsu_misalign;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_ysyx_24090003_lsu_wb.sv
// Bench for ysyx_24090003_lsu_wb: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written reset/stray-response sequences.
module tb_ysyx_24090003_lsu_wb;
  import ysyx_24090003_pkg::*;

  logic        cpu_clk;
  logic        cpu_rs;
  logic        ex_valid;
  logic        ex_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] alu_result;
  logic [4:0]  rd_in;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        lsu_done;
  logic        lsu_misalign;
  logic [1:0]  dbg_state;

  ysyx_24090003_lsu_wb #(.XLEN(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rs(cpu_rs),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .alu_result(alu_result), .rd_in(rd_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .lsu_done(lsu_done), .lsu_misalign(lsu_misalign), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          stall;
    int          rwait;
    logic        exp_wen;
    logic [31:0] exp_rfd;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwd;
    logic        exp_mis;
  } op_t;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (((a % 4) / 2) * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d % 256) * 32'h01010101;
      3'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic model_mis(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic m;
    if (ld)      m = (((f3 == 3'd1) || (f3 == 3'd5)) && (a % 2 != 0)) || ((f3 == 3'd2) && (a % 4 != 0));
    else if (st) m = ((f3 == 3'd1) && (a % 2 != 0)) || ((f3 == 3'd2) && (a % 4 != 0));
    else         m = 1'b0;
`ifndef YSYX_24090003_MISALIGN_CHK_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  function automatic op_t mk(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                             input logic [4:0] rd, input logic [31:0] rdata, input int stall,
                             input int rwait, input logic ew, input logic [31:0] erfd,
                             input logic [3:0] emask, input logic [31:0] emwd);
    op_t t;
    t.ld = ld; t.st = st; t.f3 = f3; t.addr = a; t.sdata = sd; t.alu = alu; t.rd = rd;
    t.rdata = rdata; t.stall = stall; t.rwait = rwait; t.exp_wen = ew; t.exp_rfd = erfd;
    t.exp_mask = emask; t.exp_mwd = emwd; t.exp_mis = 1'b0;
    return t;
  endfunction

  function automatic op_t rand_op();
    op_t t;
    int kind;
    kind    = $urandom_range(0, 3);
    t.ld    = (kind == 1) || (kind == 3);
    t.st    = (kind == 2) || (kind == 3);
    t.f3    = 3'($urandom_range(0, 7));
    t.addr  = $urandom;
    t.sdata = $urandom;
    t.alu   = $urandom;
    t.rd    = 5'($urandom_range(0, 31));
    t.rdata = $urandom;
    t.stall = $urandom_range(0, 2);
    t.rwait = $urandom_range(0, 2);
    t.exp_mis  = model_mis(t.ld, t.st, t.f3, t.addr);
    t.exp_wen  = !t.exp_mis && (t.ld || !t.st) && (t.rd != 5'd0);
    t.exp_rfd  = t.ld ? model_load(t.f3, t.addr, t.rdata) : t.alu;
    t.exp_mask = model_mask(t.f3, t.addr);
    t.exp_mwd  = model_wdata(t.f3, t.sdata);
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic scramble_inputs();
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    alu_result = $urandom;
    rd_in      = 5'($urandom);
  endtask

  task automatic check_wb(input op_t t);
    check("wb_done", lsu_done, 1'b1);
    check("wb_rf_wen", rf_wen, t.exp_wen);
    check("wb_misalign", lsu_misalign, t.exp_mis);
    check("wb_req_valid", mem_req_valid, 1'b0);
    check("wb_ex_ready", ex_ready, 1'b0);
    if (t.exp_wen) begin
      check("wb_rf_rd", rf_rd, t.rd);
      if (exp_q.size() > 0) check("wb_rf_wdata", rf_wdata, exp_q.pop_front());
      else check("wb_exp_q_empty", 32'd0, 32'd1);
    end
  endtask

  task automatic run_op(input op_t t);
    check("idle_ex_ready", ex_ready, 1'b1);
    ex_valid   = 1'b1;
    is_load    = t.ld;
    is_store   = t.st;
    funct3     = t.f3;
    addr       = t.addr;
    store_data = t.sdata;
    alu_result = t.alu;
    rd_in      = t.rd;
    tick();
    ex_valid = 1'b0;
    scramble_inputs();
    if (t.exp_wen) exp_q.push_back(t.exp_rfd);
    if (t.exp_mis || !(t.ld || t.st)) begin
      check_wb(t);
    end else begin
      for (int c = 0; c <= t.stall; c++) begin
        check("req_valid", mem_req_valid, 1'b1);
        check("req_ex_ready", ex_ready, 1'b0);
        check("req_addr", mem_addr, t.addr & 32'hFFFF_FFFC);
        check("req_wen", mem_req_wen, t.st && !t.ld);
        if (t.st && !t.ld) begin
          check("req_wmask", mem_wmask, t.exp_mask);
          check("req_wdata", mem_wdata, t.exp_mwd);
        end
        mem_req_ready = (c == t.stall);
        tick();
      end
      mem_req_ready = 1'b0;
      for (int c = 0; c < t.rwait; c++) begin
        check("wait_req_valid", mem_req_valid, 1'b0);
        check("wait_done", lsu_done, 1'b0);
        tick();
      end
      mem_resp_valid = 1'b1;
      mem_rdata      = t.rdata;
      check("wait_done_pre", lsu_done, 1'b0);
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      check_wb(t);
    end
    tick();
    check("post_done", lsu_done, 1'b0);
    check("post_rf_wen", rf_wen, 1'b0);
    check("post_ex_ready", ex_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  op_t tbl[13];

  initial begin
    op_t t;
    cpu_rs = 1'b1; ex_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = 32'h0; scramble_inputs();
    tick();
    tick();
    check("rst_ex_ready", ex_ready, 1'b1);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_wen", mem_req_wen, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wmask", mem_wmask, 4'h0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_rf_rd", rf_rd, 5'd0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    check("rst_done", lsu_done, 1'b0);
    check("rst_misalign", lsu_misalign, 1'b0);
    check("rst_state", dbg_state, IDLE);
    cpu_rs = 1'b0;
    tick();

    tbl[0]  = mk(0, 0, 3'd0, 32'h0,         32'h0,         32'h1234, 5'd5,  32'h0,         0, 0, 1, 32'h1234,     4'h0,    32'h0);
    tbl[1]  = mk(1, 0, LB,   32'h8000_0003, 32'h0,         32'h0,    5'd7,  32'h80FF_FF7F, 0, 2, 1, 32'hFFFF_FF80, 4'h0,    32'h0);
    tbl[2]  = mk(1, 0, LBU,  32'h8000_0003, 32'h0,         32'h0,    5'd8,  32'h80FF_FF7F, 0, 2, 1, 32'h0000_0080, 4'h0,    32'h0);
    tbl[3]  = mk(0, 1, SH,   32'h8000_0002, 32'hABCD_1234, 32'h0,    5'd9,  32'h0,         0, 0, 0, 32'h0,        4'b1100, 32'h1234_1234);
    tbl[4]  = mk(0, 1, SW,   32'h8000_0010, 32'hDEAD_BEEF, 32'h0,    5'd1,  32'h0,         3, 0, 0, 32'h0,        4'hF,    32'hDEAD_BEEF);
    tbl[5]  = mk(1, 0, LW,   32'h8000_0020, 32'h0,         32'h0,    5'd0,  32'h1122_3344, 0, 1, 0, 32'h0,        4'h0,    32'h0);
    tbl[6]  = mk(1, 0, LH,   32'h8000_0006, 32'h0,         32'h0,    5'd10, 32'h8001_0000, 1, 0, 1, 32'hFFFF_8001, 4'h0,    32'h0);
    tbl[7]  = mk(1, 0, LHU,  32'h8000_0006, 32'h0,         32'h0,    5'd11, 32'h8001_0000, 0, 0, 1, 32'h0000_8001, 4'h0,    32'h0);
    tbl[8]  = mk(0, 1, SB,   32'h0000_0101, 32'h0000_00A5, 32'h0,    5'd3,  32'h0,         0, 0, 0, 32'h0,        4'b0010, 32'hA5A5_A5A5);
    tbl[9]  = mk(1, 1, LW,   32'h8000_0044, 32'h0000_0055, 32'h0,    5'd12, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D, 4'h0,    32'h0);
    tbl[10] = mk(0, 0, 3'd0, 32'h0,         32'h0,         32'hFFFF, 5'd0,  32'h0,         0, 0, 0, 32'h0,        4'h0,    32'h0);
    tbl[11] = mk(1, 0, LH,   32'h8000_0000, 32'h0,         32'h0,    5'd13, 32'h1234_7FFF, 0, 0, 1, 32'h0000_7FFF, 4'h0,    32'h0);
    tbl[12] = mk(1, 0, LB,   32'h8000_0000, 32'h0,         32'h0,    5'd14, 32'h0000_00FE, 2, 1, 1, 32'hFFFF_FFFE, 4'h0,    32'h0);
    for (int i = 0; i < 13; i++) run_op(tbl[i]);

    // Misaligned word load: trapped with the check enabled, executed as a word otherwise.
    t = mk(1, 0, LW, 32'h8000_0002, 32'h0, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D, 4'h0, 32'h0);
    t.exp_mis = model_mis(t.ld, t.st, t.f3, t.addr);
    t.exp_wen = !t.exp_mis;
    run_op(t);

    for (int i = 0; i < 80; i++) run_op(rand_op());

    // Reset while waiting for the response, then a stray response.
    ex_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h8000_0100; rd_in = 5'd3;
    tick();
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rstwait_in_wait", dbg_state, WAIT);
    cpu_rs = 1'b1;
    tick();
    cpu_rs = 1'b0;
    check("rstwait_state", dbg_state, IDLE);
    check("rstwait_ex_ready", ex_ready, 1'b1);
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rstwait_rf_wen", rf_wen, 1'b0);
      check("rstwait_done", lsu_done, 1'b0);
      check("rstwait_idle", dbg_state, IDLE);
      tick();
    end

    // Reset during a stalled request drops mem_req_valid the next cycle.
    ex_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = SW; addr = 32'h8000_0200;
    tick();
    ex_valid = 1'b0;
    check("rstreq_valid_before", mem_req_valid, 1'b1);
    cpu_rs = 1'b1;
    tick();
    cpu_rs = 1'b0;
    check("rstreq_valid_after", mem_req_valid, 1'b0);
    check("rstreq_done", lsu_done, 1'b0);
    check("rstreq_ex_ready", ex_ready, 1'b1);
    tick();

    // Response in IDLE is ignored.
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("idle_resp_done", lsu_done, 1'b0);
    check("idle_resp_state", dbg_state, IDLE);
    tick();

    // Final report.
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
